// File: rtl/parity_pkg.sv
// Shared constants for the parity stream checker: lane geometry and the
// parity-mode encoding seen on the odd_mode input.
package parity_pkg;

    // Default data bits per lane. The lane adds one parity bit on top.
    localparam int DEFAULT_DATA_W = 8;
    localparam int PARITY_BITS    = 1;

    // Encoding of odd_mode.
    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    // Width of one lane on the input bus: data plus its parity bit.
    function automatic int lane_width(input int data_w);
        return data_w + PARITY_BITS;
    endfunction

endpackage : parity_pkg

// File: rtl/parity_lane.sv
// Combinational parity check for one lane ({parity, data}); flags the lane
// when its ones count disagrees with the requested odd/even mode.
module parity_lane
    import parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W:0] lane_word,
    input  logic            odd_mode,
    output logic            lane_err
);

    // Reduction XOR is 1 when the ones count is odd.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        lane_err = 1'b0;
        unique case (odd_mode)
            MODE_ODD:  lane_err = ~(^lane_word);
            MODE_EVEN: lane_err = ^lane_word;
        endcase
    end

endmodule : parity_lane

// File: rtl/parity_stream_checker.sv
// Parity stream checker: one valid/ready register stage that strips the
// parity bit from every lane and reports per-lane parity errors, plus a
// sticky error flag. Defining PARITY_ERR_CNT_EN adds a saturating count of
// erroring words on the err_cnt port.
module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*(DATA_W+1)-1:0]       in_word,
    input  logic                              odd_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*DATA_W-1:0]           out_data,
    output logic [LANES-1:0]                  out_err,
    output logic                              sticky_err,
    input  logic                              err_clr
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]                  err_cnt
`endif
);

    localparam int LANE_W = lane_width(DATA_W);

    // The counter width must be usable even when the counter is not built.
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    logic [LANES-1:0]        lane_err;
    logic [LANES*DATA_W-1:0] data_strip;
    logic                    accept;
    logic                    any_err;

    logic                    out_valid_d, out_valid_q;
    logic [LANES*DATA_W-1:0] out_data_d,  out_data_q;
    logic [LANES-1:0]        out_err_d,   out_err_q;
    logic                    sticky_d,    sticky_q;

    // One checker per lane; the parity bit is dropped from the forwarded data.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        parity_lane #(.DATA_W(DATA_W)) u_lane (
            .lane_word (in_word[i*LANE_W +: LANE_W]),
            .odd_mode  (odd_mode),
            .lane_err  (lane_err[i])
        );
        assign data_strip[i*DATA_W +: DATA_W] = in_word[i*LANE_W +: DATA_W];
    end

    // The stage can take a word when empty or when its content leaves this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign any_err  = |lane_err;

    // Output stage next state: load on accept, empty on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = data_strip;
            out_err_d   = lane_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Sticky flag: a new error in the same cycle as err_clr wins.
    always_comb begin
        sticky_d = sticky_q;
        if (err_clr)            sticky_d = 1'b0;
        if (accept && any_err)  sticky_d = 1'b1;
    end

    // Output stage and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            // NOTE: the data register is reset too, because out_data must read zero during reset.
            out_data_q  <= '0;
            out_err_q   <= '0;
            sticky_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign sticky_err = sticky_q;

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q, cnt_base;

    // Count erroring words at acceptance; clear first so a same-cycle error lands on 1.
    always_comb begin
        cnt_base = err_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (accept && any_err && (cnt_base != {CNT_W{1'b1}})) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign err_cnt = cnt_q;
`endif

endmodule : parity_stream_checker

// File: tb/tb_parity_stream_checker.sv
// Directed bench for parity_stream_checker with DATA_W=8, LANES=2, CNT_W=2.
// Counter checks are compiled in when PARITY_ERR_CNT_EN is defined.
module tb_parity_stream_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_word;
    logic        odd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_err;
    logic        sticky_err;
    logic        err_clr;
`ifdef PARITY_ERR_CNT_EN
    logic [1:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    parity_stream_checker #(.DATA_W(8), .LANES(2), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .odd_mode   (odd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .sticky_err (sticky_err),
        .err_clr    (err_clr)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane word builder: lane i = {parity, data}.
    function automatic logic [17:0] mk(input logic p0, input logic [7:0] d0,
                                       input logic p1, input logic [7:0] d1);
        return {p1, d1, p0, d0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] w, input logic mode);
        in_valid = 1'b1;
        in_word  = w;
        odd_mode = mode;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_word = '0; odd_mode = 1'b1;
        out_ready = 1'b0; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL reset_out_err: got %b expected 00", out_err); end
        checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", sticky_err); end
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
`endif
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_odd_clean();
        out_ready = 1'b1;
        send(mk(1'b0, 8'h01, 1'b1, 8'h00), 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL odd_clean_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL odd_clean_data: got %h expected 0001", out_data); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL odd_clean_err: got %b expected 00", out_err); end
        checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL odd_clean_sticky: got %b expected 0", sticky_err); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL odd_clean_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_odd_lane0_bad();
        send(mk(1'b0, 8'h03, 1'b0, 8'h01), 1'b1);
        checks++; if (out_err !== 2'b01) begin errors++; $display("FAIL odd_bad_err: got %b expected 01", out_err); end
        checks++; if (out_data !== 16'h0103) begin errors++; $display("FAIL odd_bad_data: got %h expected 0103", out_data); end
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL odd_bad_sticky: got %b expected 1", sticky_err); end
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL odd_bad_cnt: got %0d expected 1", err_cnt); end
`endif
        // A clean word afterwards must leave the sticky flag set.
        send(mk(1'b0, 8'h01, 1'b1, 8'h00), 1'b1);
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL sticky_hold_err: got %b expected 00", out_err); end
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL sticky_hold: got %b expected 1", sticky_err); end
    endtask

    task automatic test_even_both_bad();
        send(mk(1'b0, 8'h01, 1'b1, 8'h00), 1'b0);
        checks++; if (out_err !== 2'b11) begin errors++; $display("FAIL even_bad_err: got %b expected 11", out_err); end
        checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL even_bad_data: got %h expected 0001", out_data); end
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd2) begin errors++; $display("FAIL even_bad_cnt: got %0d expected 2", err_cnt); end
`endif
        step();
    endtask

    task automatic test_clear();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL clear_sticky: got %b expected 0", sticky_err); end
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL clear_cnt: got %0d expected 0", err_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        odd_mode  = 1'b1;
        in_word   = mk(1'b0, 8'h01, 1'b1, 8'h00);   // A: clean, data 0001
        step();
        in_word   = mk(1'b1, 8'h80, 1'b0, 8'h7F);   // B: lane 0 bad, data 7F80
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL bp_data[%0d]: got %h expected 0001", i, out_data); end
            checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL bp_err[%0d]: got %b expected 00", i, out_err); end
            step();
        end
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL bp_cnt_stalled: got %0d expected 0", err_cnt); end
`endif
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b expected 1", in_ready); end
        step();
        checks++; if (out_data !== 16'h7F80) begin errors++; $display("FAIL b2b_data_b: got %h expected 7f80", out_data); end
        checks++; if (out_err !== 2'b01) begin errors++; $display("FAIL b2b_err_b: got %b expected 01", out_err); end
        in_word = mk(1'b0, 8'h07, 1'b0, 8'hFF);     // C: lane 1 bad, data FF07
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_c: got %b expected 1", out_valid); end
        checks++; if (out_data !== 16'hFF07) begin errors++; $display("FAIL b2b_data_c: got %h expected ff07", out_data); end
        checks++; if (out_err !== 2'b10) begin errors++; $display("FAIL b2b_err_c: got %b expected 10", out_err); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd2) begin errors++; $display("FAIL b2b_cnt: got %0d expected 2", err_cnt); end
`endif
    endtask

    task automatic test_saturation();
        err_clr = 1'b1;
        step();
        err_clr  = 1'b0;
        in_valid = 1'b1;
        odd_mode = 1'b1;
        in_word  = mk(1'b0, 8'h03, 1'b0, 8'h01);   // lane 0 bad
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d expected 3", err_cnt); end
`endif
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", sticky_err); end
        // Clear and a new erroring word in the same cycle: the error wins.
        err_clr  = 1'b1;
        in_valid = 1'b1;
        step();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL clr_vs_err_sticky: got %b expected 1", sticky_err); end
        checks++; if (out_err !== 2'b01) begin errors++; $display("FAIL clr_vs_err_err: got %b expected 01", out_err); end
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL clr_vs_err_cnt: got %0d expected 1", err_cnt); end
`endif
        step();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        send(mk(1'b0, 8'h03, 1'b0, 8'h01), 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_stall_data: got %h expected 0000", out_data); end
        checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL rst_stall_sticky: got %b expected 0", sticky_err); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b expected 0", out_valid); end
        checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL post_rst_err: got %b expected 00", out_err); end
`ifdef PARITY_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL post_rst_cnt: got %0d expected 0", err_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_odd_clean();
        test_odd_lane0_bad();
        test_even_both_bad();
        test_clear();
        test_backpressure();
        test_saturation();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_parity_stream_checker
